mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data, memory and status signals around the arbiter.
// master: arbiter side; slave: core/memory environment side.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [XLEN-1:0]   dm_addr;
  logic [XLEN-1:0]   dm_wdata;
  logic [XLEN/8-1:0] dm_be;
  logic              dm_valid;
  logic [XLEN-1:0]   dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              err_timeout;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_valid, if_rdata,
    input  dm_req, dm_we, dm_addr,
    input  dm_wdata, dm_be,
    output dm_valid, dm_rdata,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ack, mem_rdata,
    output stall_if, stall_mem,
    output err_timeout
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_valid, if_rdata,
    output dm_req, dm_we, dm_addr,
    output dm_wdata, dm_be,
    input  dm_valid, dm_rdata,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ack, mem_rdata,
    input  stall_if, stall_mem,
    input  err_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction in flight; fetch is protected from data starvation.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SW-1:0]     starve_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              drop;
  logic              err_q;

  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [XLEN/8-1:0] be_q;

  logic grant_if;
  logic grant_dm;
  logic ack_if;
  logic ack_dm;
  logic tmo_hit;
  logic tmo_last;
  logic starve_hit;
  logic fetch_ok;

  assign tmo_last   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign fetch_ok   = bus.if_req & ~bus.if_flush;

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    ack_if    = 1'b0;
    ack_dm    = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_ok &&
            (starve_hit || !bus.dm_req)) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (bus.dm_req) begin
          grant_dm  = 1'b1;
          state_nxt = BUSY_DM;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack) begin
          ack_if    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_last) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack) begin
          ack_dm    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_last) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= tmo_hit;
    end
  end

  // Fetches are always full-word reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else if (grant_if) begin
      addr_q  <= bus.if_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '1;
    end else if (grant_dm) begin
      addr_q  <= bus.dm_addr;
      wdata_q <= bus.dm_wdata;
      we_q    <= bus.dm_we;
      be_q    <= bus.dm_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && bus.if_req) begin
        if (!starve_hit) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else if (!bus.if_req) begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (grant_if || grant_dm) begin
      tmo_cnt <= '0;
    end else if (state != IDLE && !bus.mem_ack) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // A flushed fetch still drains on the bus; only its result is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop <= 1'b0;
    end else if (state_nxt == IDLE) begin
      drop <= 1'b0;
    end else if (state == BUSY_IF && bus.if_flush) begin
      drop <= 1'b1;
    end
  end

  assign bus.mem_req   = (state != IDLE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign bus.if_valid  = ack_if & ~drop & ~bus.if_flush;
  assign bus.if_rdata  = bus.if_valid ?
                         bus.mem_rdata[31:0] : 32'd0;
  assign bus.dm_valid  = ack_dm;
  assign bus.dm_rdata  = bus.dm_valid ?
                         bus.mem_rdata : '0;

  assign bus.stall_if    = bus.if_req & ~bus.if_valid;
  assign bus.stall_mem   = bus.dm_req & ~bus.dm_valid;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, starvation,
// flush, timeout and reset-abandon scenarios.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_be     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    int bad;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_dm_valid", bus.dm_valid, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    step();

    // fetch only, ack two cycles after mem_req
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    step();
    check("f_mem_req", bus.mem_req, 1);
    check("f_mem_addr", bus.mem_addr, 32'h10);
    check("f_mem_we", bus.mem_we, 0);
    check("f_mem_be", bus.mem_be, 4'hF);
    check("f_stall", bus.stall_if, 1);
    step();
    check("f_hold", bus.mem_req, 1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    #1;
    check("f_valid", bus.if_valid, 1);
    check("f_rdata", bus.if_rdata, 32'h00500093);
    check("f_stall_off", bus.stall_if, 0);
    check("f_dm_rdata0", bus.dm_rdata, 0);
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    check("f_idle", bus.mem_req, 0);

    // stray ack in IDLE
    bus.mem_ack = 1'b1;
    #1;
    check("idle_ack_if", bus.if_valid, 0);
    check("idle_ack_dm", bus.dm_valid, 0);
    step();
    bus.mem_ack = 1'b0;

    // store and fetch together: store first
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'hDEADBEEF;
    bus.dm_be    = 4'hF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h20;
    step();
    check("s_mem_we", bus.mem_we, 1);
    check("s_mem_addr", bus.mem_addr, 32'h40);
    check("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("s_mem_be", bus.mem_be, 4'hF);
    check("s_stall_if", bus.stall_if, 1);
    check("s_stall_mem", bus.stall_mem, 1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    #1;
    check("s_dm_valid", bus.dm_valid, 1);
    check("s_dm_rdata", bus.dm_rdata, 32'h12345678);
    check("s_if_valid", bus.if_valid, 0);
    check("s_stall_mem0", bus.stall_mem, 0);
    step();
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;
    check("s_gap_stall", bus.stall_if, 1);
    check("s_gap_req", bus.mem_req, 0);
    step();
    check("s_f_addr", bus.mem_addr, 32'h20);
    check("s_f_we", bus.mem_we, 0);
    check("s_f_stall", bus.stall_if, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    #1;
    check("s_f_valid", bus.if_valid, 1);
    check("s_f_rdata", bus.if_rdata, 32'hCAFEF00D);
    check("s_f_stall0", bus.stall_if, 0);
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    step();

    // starvation: 4 data grants, then the fetch
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h100;
    bus.dm_be   = 4'h3;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    for (int g = 0; g < 5; g++) begin
      step();
      if (g < 4) begin
        check($sformatf("st_addr%0d", g),
              bus.mem_addr, 32'h100);
        check($sformatf("st_be%0d", g),
              bus.mem_be, 4'h3);
      end else begin
        check("st_f_addr", bus.mem_addr, 32'h80);
        check("st_f_be", bus.mem_be, 4'hF);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1000 + g;
      #1;
      check($sformatf("st_dmv%0d", g),
            bus.dm_valid, (g < 4));
      check($sformatf("st_ifv%0d", g),
            bus.if_valid, (g == 4));
      step();
      bus.mem_ack = 1'b0;
      if (g == 4) begin
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
      end
    end
    step();

    // flush in IDLE suppresses the grant
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h30;
    bus.if_flush = 1'b1;
    step();
    check("fl_idle_req", bus.mem_req, 0);
    bus.if_flush = 1'b0;
    step();
    check("fl_busy", bus.mem_req, 1);
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55;
    #1;
    check("fl_valid", bus.if_valid, 0);
    check("fl_rdata", bus.if_rdata, 0);
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    check("fl_idle", bus.mem_req, 0);
    step();

    // drop flag cleared: next fetch delivers
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h34;
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    #1;
    check("fl2_valid", bus.if_valid, 1);
    check("fl2_rdata", bus.if_rdata, 32'h77);
    step();
    bus.mem_ack = 1'b0;
    step();

    // flush coincident with ack (if_req still held)
    bus.mem_ack  = 1'b1;
    bus.if_flush = 1'b1;
    #1;
    check("flc_valid", bus.if_valid, 0);
    step();
    bus.mem_ack  = 1'b0;
    bus.if_flush = 1'b0;
    bus.if_req   = 1'b0;
    check("flc_idle", bus.mem_req, 0);
    step();

    // timeout after 64 BUSY cycles without ack
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h200;
    step();
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (!bus.mem_req || bus.err_timeout
          || bus.dm_valid)
        bad++;
    end
    check("to_hold", bad, 0);
    check("to_last_req", bus.mem_req, 1);
    bus.dm_req = 1'b0;
    step();
    check("to_req_drop", bus.mem_req, 0);
    check("to_err", bus.err_timeout, 1);
    check("to_no_valid", bus.dm_valid, 0);
    step();
    check("to_err_once", bus.err_timeout, 0);

    // reset in BUSY_DM abandons the store
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h44;
    bus.dm_wdata = 32'h11;
    step();
    check("rb_busy", bus.mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rb_req_async", bus.mem_req, 0);
    check("rb_addr_async", bus.mem_addr, 0);
    bus.dm_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    bus.mem_ack = 1'b1;
    #1;
    check("rb_stray_dm", bus.dm_valid, 0);
    check("rb_stray_req", bus.mem_req, 0);
    step();
    bus.mem_ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
